mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one 32-bit memory port between two requesters: instruction fetch (port 0)
// and load/store (port 1). Sequences one transaction at a time and drives the
// select of the mux32 instances that steer address and write data onto the port.
// Returns read data and a one-cycle completion pulse to the winning requester.
// A bounded wait aborts a stalled transaction.
// PARAMETERS
// PRIORITY_MODE  0        0 = round-robin on ties; 1 = fixed, port 1 always wins ties
// TIMEOUT        16       max cycles waiting in WAIT for mem_ready; 0 = no timeout
// PORTS
// clk        in   1   clock, all state on rising edge
// reset      in   1   asynchronous, active-high reset
// req0       in   1   port 0 request (read only)
// addr0      in   32  port 0 address
// req1       in   1   port 1 request
// addr1      in   32  port 1 address
// wdata1     in   32  port 1 write data
// we1        in   1   port 1 write enable
// sel        out  1   mux select: 0 = port 0, 1 = port 1 (drives mux32 control)
// mem_addr   out  32  sel ? addr1 : addr0 (combinational, via mux32)
// mem_wdata  out  32  wdata1
// mem_we     out  1   we1 & sel & mem_valid
// mem_valid  out  1   transaction request to memory
// mem_ready  in   1   memory completion, sampled only in WAIT
// mem_rdata  in   32  memory read data, valid with mem_ready
// gnt0/gnt1  out  1   port owns memory (ISSUE..WAIT)
// done0/done1 out 1   one-cycle completion pulse (RESP)
// rdata      out  32  captured read data, held until next capture
// err        out  1   one-cycle pulse with done_x when transaction timed out
// BEHAVIOUR
// - Reset (async): state=IDLE, sel=0, gnt0/1=0, done0/1=0, mem_valid=0,
//   rdata=0, err=0, wait counter=0, last_winner=1 (port 0 wins first tie).
// - FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: if req0|req1 at edge: register sel=winner, gnt_winner=1, mem_valid=1,
//     counter=0, go WAIT. Single requester wins. Tie: PRIORITY_MODE=0 grants
//     ~last_winner; PRIORITY_MODE=1 grants port 1. last_winner updated on grant.
//   WAIT: mem_valid held 1, sel frozen. mem_ready=1 at edge: rdata<=mem_rdata
//     (rdata<=mem_rdata also on writes), mem_valid=0, gnt=0, done_winner=1, go RESP.
//     Else counter++; if TIMEOUT!=0 and counter==TIMEOUT-1 at edge: mem_valid=0,
//     gnt=0, done_winner=1, err=1, rdata<=0, go RESP.
//   RESP: done/err high this cycle only; no arbitration; next edge -> IDLE,
//     done/err cleared.
// - Latency: req at edge N -> mem_valid high after N; mem_ready at edge N+1 ->
//   done high in cycle N+2; earliest next grant at edge N+3.
// - Requesters hold req/addr/wdata/we stable until done; dropping req during WAIT
//   is ignored and the transaction completes. Requester must deassert req in its
//   done cycle or it is re-arbitrated in IDLE.
// - mem_ready outside WAIT is ignored. Mid-transaction reset: mem_valid drops
//   immediately, no done pulse issued.
// - Counter width $clog2(TIMEOUT+1); no wrap reachable.
// TESTING
// - req0 only, addr0=0x100, mem_ready one cycle after valid, rdata=0xDEADBEEF ->
//   sel=0, mem_addr=0x100, done0 pulse one cycle, rdata=0xDEADBEEF, err=0.
// - req0&req1 held high, PRIORITY_MODE=0, 4 transactions -> grants 0,1,0,1;
//   PRIORITY_MODE=1 -> grants 1,1,1,1.
// - req1, we1=1, addr1=0x200, wdata1=0x12345678 -> mem_we=1 only while valid,
//   mem_wdata=0x12345678, done1 pulse.
// - TIMEOUT=16, mem_ready never -> mem_valid high exactly 16 cycles, then done0+err
//   pulse, rdata=0; next request served normally.
// - reset asserted in WAIT -> outputs return to reset values same cycle, no done;
//   after release, tie grants port 0.
// - mem_ready pulsed in IDLE/RESP -> ignored; req0 dropped in WAIT -> done0 still issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing a single 32-bit memory port between instruction
// fetch (port 0) and load/store (port 1), one transaction at a time, with bounded wait.

module mux32 (
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = s ? b : a;
endmodule

module mem_port_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    output logic        sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          sel_nxt;
    logic          gnt0_nxt, gnt1_nxt;
    logic          done0_nxt, done1_nxt;
    logic          mem_valid_nxt;
    logic [31:0]   rdata_nxt;
    logic          err_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          last_winner, last_winner_nxt;

    logic          winner;
    logic          timeout_hit;

    // A lone requester always wins; ties go by mode (alternate or port 1 fixed).
    always_comb begin
        winner = 1'b0;
        if (req1 && !req0) begin
            winner = 1'b1;
        end else if (req1 && req0) begin
            winner = (PRIORITY_MODE == 1) ? 1'b1 : ~last_winner;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST_CNT);

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        gnt0_nxt        = gnt0;
        gnt1_nxt        = gnt1;
        done0_nxt       = 1'b0;
        done1_nxt       = 1'b0;
        mem_valid_nxt   = mem_valid;
        rdata_nxt       = rdata;
        err_nxt         = 1'b0;
        wait_cnt_nxt    = wait_cnt;
        last_winner_nxt = last_winner;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt       = WAIT;
                    sel_nxt         = winner;
                    gnt0_nxt        = ~winner;
                    gnt1_nxt        = winner;
                    mem_valid_nxt   = 1'b1;
                    wait_cnt_nxt    = '0;
                    last_winner_nxt = winner;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt     = RESP;
                    rdata_nxt     = mem_rdata;
                    mem_valid_nxt = 1'b0;
                    gnt0_nxt      = 1'b0;
                    gnt1_nxt      = 1'b0;
                    done0_nxt     = ~sel;
                    done1_nxt     = sel;
                end else if (timeout_hit) begin
                    state_nxt     = RESP;
                    rdata_nxt     = '0;
                    mem_valid_nxt = 1'b0;
                    gnt0_nxt      = 1'b0;
                    gnt1_nxt      = 1'b0;
                    done0_nxt     = ~sel;
                    done1_nxt     = sel;
                    err_nxt       = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                mem_valid_nxt = 1'b0;
                gnt0_nxt      = 1'b0;
                gnt1_nxt      = 1'b0;
            end
        endcase
    end

    // last_winner resets to 1 so the first tie after reset goes to port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            mem_valid   <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            wait_cnt    <= '0;
            last_winner <= 1'b1;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            gnt0        <= gnt0_nxt;
            gnt1        <= gnt1_nxt;
            done0       <= done0_nxt;
            done1       <= done1_nxt;
            mem_valid   <= mem_valid_nxt;
            rdata       <= rdata_nxt;
            err         <= err_nxt;
            wait_cnt    <= wait_cnt_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    mux32 u_addr_mux (
        .s (sel),
        .a (addr0),
        .b (addr1),
        .y (mem_addr)
    );

    assign mem_wdata = wdata1;
    assign mem_we    = we1 & sel & mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.

module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we1, mem_ready;
    logic [31:0] addr0, addr1, wdata1, mem_rdata;

    logic        sel, mem_we, mem_valid, gnt0, gnt1, done0, done1, err;
    logic [31:0] mem_addr, mem_wdata, rdata;

    logic        b_sel, b_mem_we, b_mem_valid, b_gnt0, b_gnt1, b_done0, b_done1, b_err;
    logic [31:0] b_mem_addr, b_mem_wdata, b_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .req1(req1),
        .addr1(addr1), .wdata1(wdata1), .we1(we1), .sel(sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err)
    );

    mem_port_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(16)) dut_fixed (
        .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .req1(req1),
        .addr1(addr1), .wdata1(wdata1), .we1(we1), .sel(b_sel), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_valid(b_mem_valid),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .gnt0(b_gnt0), .gnt1(b_gnt1),
        .done0(b_done0), .done1(b_done1), .rdata(b_rdata), .err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 0; req1 = 0; we1 = 0; mem_ready = 0;
        addr0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
        step();
        step();
        checks++;
        if ({sel, gnt0, gnt1, done0, done1, mem_valid, err, mem_we} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {sel, gnt0, gnt1, done0, done1, mem_valid, err, mem_we});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_read();
        req0 = 1; addr0 = 32'h100;
        step();
        checks++;
        if ({mem_valid, sel, gnt0, gnt1} !== 4'b1010 || mem_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL read_issue: got valid/sel/g0/g1=%b addr=%h expected 1010 addr=00000100",
                     {mem_valid, sel, gnt0, gnt1}, mem_addr);
        end
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        step();
        checks++;
        if ({done0, done1, err, mem_valid} !== 4'b1000 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_done: got d0/d1/err/valid=%b rdata=%h expected 1000 rdata=deadbeef",
                     {done0, done1, err, mem_valid}, rdata);
        end
        mem_ready = 0; req0 = 0;
        step();
        checks++;
        if (done0 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_pulse: got done0=%b rdata=%h expected 0 deadbeef", done0, rdata);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_rr;
        do_reset();
        exp_rr = 4'b1010;
        req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (sel !== exp_rr[i] || gnt1 !== exp_rr[i] || gnt0 !== ~exp_rr[i]) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got sel=%b g0=%b g1=%b expected sel=%b",
                         i, sel, gnt0, gnt1, exp_rr[i]);
            end
            checks++;
            if (b_sel !== 1'b1 || b_gnt1 !== 1'b1 || b_mem_addr !== 32'hB0) begin
                errors++;
                $display("[TB] FAIL fixed_grant%0d: got sel=%b g1=%b addr=%h expected 1 1 000000b0",
                         i, b_sel, b_gnt1, b_mem_addr);
            end
            mem_ready = 1; mem_rdata = 32'h1000 + i;
            step();
            mem_ready = 0;
            step();
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_write();
        req1 = 1; we1 = 1; addr1 = 32'h200; wdata1 = 32'h12345678;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_idle_we: got %b expected 0", mem_we);
        end
        step();
        checks++;
        if ({mem_we, sel, gnt1} !== 3'b111 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL write_issue: got we/sel/g1=%b addr=%h wdata=%h expected 111 00000200 12345678",
                     {mem_we, sel, gnt1}, mem_addr, mem_wdata);
        end
        mem_ready = 1; mem_rdata = 32'hAAAA5555;
        step();
        checks++;
        if ({done1, done0, mem_we, err} !== 4'b1000 || rdata !== 32'hAAAA5555) begin
            errors++;
            $display("[TB] FAIL write_done: got d1/d0/we/err=%b rdata=%h expected 1000 aaaa5555",
                     {done1, done0, mem_we, err}, rdata);
        end
        mem_ready = 0; req1 = 0; we1 = 0;
        step();
    endtask

    task automatic test_timeout();
        int valid_cycles;
        bit ended;
        req0 = 1; addr0 = 32'h300; mem_ready = 0;
        step();
        valid_cycles = mem_valid ? 1 : 0;
        ended = 0;
        for (int i = 0; i < 40 && !ended; i++) begin
            step();
            if (mem_valid) valid_cycles++;
            else ended = 1;
        end
        checks++;
        if (!ended || valid_cycles != 16) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d valid cycles (ended=%0d) expected 16", valid_cycles, ended);
        end
        checks++;
        if ({done0, done1, err} !== 3'b101 || rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL timeout_done: got d0/d1/err=%b rdata=%h expected 101 00000000",
                     {done0, done1, err}, rdata);
        end
        req0 = 0;
        step();
        checks++;
        if (err !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clear: got err=%b done0=%b expected 0 0", err, done0);
        end
        req0 = 1; addr0 = 32'h400;
        step();
        mem_ready = 1; mem_rdata = 32'h55;
        step();
        checks++;
        if ({done0, err} !== 2'b10 || rdata !== 32'h55) begin
            errors++;
            $display("[TB] FAIL after_timeout: got d0/err=%b rdata=%h expected 10 00000055", {done0, err}, rdata);
        end
        mem_ready = 0; req0 = 0;
        step();
    endtask

    task automatic test_reset_in_wait();
        req0 = 1; req1 = 1;
        step();
        reset = 1;
        #1;
        checks++;
        if ({mem_valid, gnt0, gnt1, sel} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid/g0/g1/sel=%b expected 0000", {mem_valid, gnt0, gnt1, sel});
        end
        step();
        checks++;
        if ({done0, done1, mem_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got d0/d1/valid=%b expected 000", {done0, done1, mem_valid});
        end
        reset = 0;
        step();
        checks++;
        if ({sel, gnt0, mem_valid} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL tie_after_reset: got sel/g0/valid=%b expected 011", {sel, gnt0, mem_valid});
        end
        mem_ready = 1;
        step();
        mem_ready = 0; req0 = 0; req1 = 0;
        step();
    endtask

    task automatic test_ignored_ready();
        mem_ready = 1; mem_rdata = 32'h99;
        step();
        checks++;
        if ({done0, done1, mem_valid} !== 3'b000 || rdata === 32'h99) begin
            errors++;
            $display("[TB] FAIL ready_in_idle: got d0/d1/valid=%b rdata=%h expected 000 and rdata not 00000099",
                     {done0, done1, mem_valid}, rdata);
        end
        mem_ready = 0; req0 = 1; addr0 = 32'h500;
        step();
        req0 = 0;
        step();
        checks++;
        if (mem_valid !== 1'b1 || gnt0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_req_wait: got valid=%b g0=%b expected 1 1", mem_valid, gnt0);
        end
        mem_ready = 1; mem_rdata = 32'h77;
        step();
        checks++;
        if (done0 !== 1'b1 || rdata !== 32'h77) begin
            errors++;
            $display("[TB] FAIL drop_req_done: got done0=%b rdata=%h expected 1 00000077", done0, rdata);
        end
        mem_rdata = 32'h88;
        step();
        checks++;
        if ({done0, mem_valid} !== 2'b00 || rdata !== 32'h77) begin
            errors++;
            $display("[TB] FAIL ready_in_resp: got d0/valid=%b rdata=%h expected 00 00000077",
                     {done0, mem_valid}, rdata);
        end
        mem_ready = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_priority();
        test_write();
        test_timeout();
        test_reset_in_wait();
        test_ignored_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
